// File: rtl/cam_rgb565_capture_if.sv
// Write port from the camera capture stage into the dual-port frame buffer.
interface cam_rgb565_capture_if #(
    parameter int AW = 15,
    parameter int DW = 8
) ();
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr;

    modport master (output mem_px_addr, output mem_px_data, output px_wr);
    modport slave  (input  mem_px_addr, input  mem_px_data, input  px_wr);
endinterface

// File: rtl/cam_rgb565_capture.sv
// OV7670-style RGB565 byte-stream capture: packs each pixel to RGB332 and
// writes one 160x120 frame into the buffer, saturating at MAX_PIX pixels.
module cam_rgb565_capture #(
    parameter int AW      = 15,
    parameter int DW      = 8,
    parameter int MAX_PIX = 19200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 capture_en,
    input  logic                 vsync,
    input  logic                 href,
    input  logic [7:0]           px_data,
    cam_rgb565_capture_if.master wr,
    output logic                 frame_done,
    output logic                 overflow,
    output logic [AW-1:0]        pix_count
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_BYTE1    = 2'd2,
        ST_BYTE2    = 2'd3
    } state_t;

    localparam logic [AW-1:0] MAX_CNT = AW'(MAX_PIX);
    localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_r;
    logic          prev_vsync_r;
    logic [5:0]    hi_r;       // only the R5 top bits and G6 top bits are kept
    logic [AW-1:0] count_r;

    logic vsync_rise_s;
    logic vsync_fall_s;
    logic in_frame_s;

    // R3 G3 B2 from the kept high-byte bits and the top two blue bits.
    function automatic logic [7:0] pack_rgb332(input logic [5:0] rg, input logic [1:0] b);
        return {rg, b};
    endfunction

    assign vsync_rise_s = vsync & ~prev_vsync_r;
    assign vsync_fall_s = ~vsync & prev_vsync_r;
    assign in_frame_s   = (state_r == ST_BYTE1) || (state_r == ST_BYTE2);

    // Capture FSM, pixel counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            prev_vsync_r    <= 1'b1;
            hi_r            <= 6'd0;
            count_r         <= {AW{1'b0}};
            wr.mem_px_addr  <= {AW{1'b0}};
            wr.mem_px_data  <= {DW{1'b0}};
            wr.px_wr        <= 1'b0;
            frame_done      <= 1'b0;
            overflow        <= 1'b0;
            pix_count       <= {AW{1'b0}};
        end else begin
            prev_vsync_r <= vsync;
            wr.px_wr     <= 1'b0;
            frame_done   <= 1'b0;
            if (in_frame_s && vsync_rise_s) begin
                // End of frame wins over any byte sampled this cycle.
                frame_done <= 1'b1;
                pix_count  <= count_r;
                state_r    <= capture_en ? ST_WAIT_SOF : ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (capture_en && vsync) begin
                            state_r <= ST_WAIT_SOF;
                        end
                    end
                    ST_WAIT_SOF: begin
                        if (vsync_fall_s) begin
                            count_r  <= {AW{1'b0}};
                            overflow <= 1'b0;
                            state_r  <= ST_BYTE1;
                        end
                    end
                    ST_BYTE1: begin
                        if (href) begin
                            hi_r    <= {px_data[7:5], px_data[2:0]};
                            state_r <= ST_BYTE2;
                        end
                    end
                    ST_BYTE2: begin
                        state_r <= ST_BYTE1;
                        if (href) begin
                            if (count_r == MAX_CNT) begin
                                overflow <= 1'b1;
                            end else begin
                                wr.px_wr       <= 1'b1;
                                wr.mem_px_addr <= count_r;
                                wr.mem_px_data <= DW'(pack_rgb332(hi_r, px_data[4:3]));
                                count_r        <= count_r + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cam_rgb565_capture.sv
// Self-checking bench for cam_rgb565_capture: scenario tasks with a pixel-level
// reference model (expected write queue built from RGB565 field arithmetic).
module tb_cam_rgb565_capture;
    localparam int AW      = 15;
    localparam int DW      = 8;
    localparam int MAX_PIX = 19200;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          capture_en;
    logic          vsync;
    logic          href;
    logic [7:0]    px_data;
    logic          frame_done;
    logic          overflow;
    logic [AW-1:0] pix_count;

    cam_rgb565_capture_if #(.AW(AW), .DW(DW)) wr_if ();

    cam_rgb565_capture #(.AW(AW), .DW(DW), .MAX_PIX(MAX_PIX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture_en (capture_en),
        .vsync      (vsync),
        .href       (href),
        .px_data    (px_data),
        .wr         (wr_if),
        .frame_done (frame_done),
        .overflow   (overflow),
        .pix_count  (pix_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [22:0]   exp_q[$];
    int            m_count;
    bit            m_ovf;

    // monitor state
    int            wr_seen = 0;
    int            fd_seen = 0;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;

    function automatic logic [7:0] rgb332(input logic [7:0] hi, input logic [7:0] lo);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        logic [4:0] r_s;
        logic [5:0] g_s;
        logic [4:0] b_s;
        r5  = hi[7:3];
        g6  = {hi[2:0], lo[7:5]};
        b5  = lo[4:0];
        r_s = r5 >> 2;
        g_s = g6 >> 3;
        b_s = b5 >> 3;
        return {r_s[2:0], g_s[2:0], b_s[1:0]};
    endfunction

    task automatic model_pixel(input logic [7:0] hi, input logic [7:0] lo);
        logic [AW-1:0] a;
        if (m_count < MAX_PIX) begin
            a = AW'(m_count);
            exp_q.push_back({a, rgb332(hi, lo)});
            m_count++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    // Every strobe is checked against the head of the expected-write queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (wr_if.px_wr === 1'b1) begin
                logic [22:0] e;
                wr_seen++;
                last_addr = wr_if.mem_px_addr;
                last_data = wr_if.mem_px_data;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL unexpected_write got addr=%0d data=%h, required no write",
                                 wr_if.mem_px_addr, wr_if.mem_px_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({wr_if.mem_px_addr, wr_if.mem_px_data} !== e) begin
                        errors++;
                        if (errors < 20)
                            $display("FAIL write got addr=%0d data=%h, required addr=%0d data=%h",
                                     wr_if.mem_px_addr, wr_if.mem_px_data, e[22:8], e[7:0]);
                    end
                end
            end
            if (frame_done === 1'b1) fd_seen++;
        end
    end

    task automatic gap(input int n);
        href = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic sof();
        href  = 1'b0;
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync   = 1'b0;
        m_count = 0;
        m_ovf   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic eof();
        href  = 1'b0;
        vsync = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pixel(input logic [7:0] hi, input logic [7:0] lo, input bit live);
        href    = 1'b1;
        px_data = hi;
        @(negedge clk);
        px_data = lo;
        if (live) model_pixel(hi, lo);
        @(negedge clk);
    endtask

    task automatic drop_pixel(input logic [7:0] hi);
        href    = 1'b1;
        px_data = hi;
        @(negedge clk);
        href    = 1'b0;
        px_data = 8'($urandom);
        @(negedge clk);
    endtask

    task automatic lines(input int n_pix, input bit live);
        for (int i = 0; i < n_pix; i++) begin
            pixel(8'($urandom), 8'($urandom), live);
            if ((i % 160) == 159) gap(2);
        end
        gap(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; capture_en = 1'b1; vsync = 1'b1; href = 1'b0; px_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({wr_if.px_wr, wr_if.mem_px_addr, wr_if.mem_px_data, frame_done, overflow, pix_count} !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs got wr=%b addr=%0d data=%h fd=%b ovf=%b cnt=%0d, required all 0",
                     wr_if.px_wr, wr_if.mem_px_addr, wr_if.mem_px_data, frame_done, overflow, pix_count);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_pixel();
        int fd0 = fd_seen;
        int w0  = wr_seen;
        sof();
        pixel(8'hF8, 8'h1F, 1'b1);
        gap(1);
        checks++;
        if (last_addr !== 15'd0 || last_data !== 8'hE3) begin
            errors++;
            $display("FAIL single_pixel0 got addr=%0d data=%h, required addr=0 data=e3", last_addr, last_data);
        end
        pixel(8'h07, 8'hE0, 1'b1);
        gap(1);
        checks++;
        if (last_addr !== 15'd1 || last_data !== 8'h1C || wr_seen - w0 != 2) begin
            errors++;
            $display("FAIL single_pixel1 got addr=%0d data=%h writes=%0d, required addr=1 data=1c writes=2",
                     last_addr, last_data, wr_seen - w0);
        end
        eof();
        checks++;
        if (fd_seen - fd0 != 1 || pix_count !== 15'd2 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL single_eof got fd=%0d cnt=%0d ovf=%b, required fd=1 cnt=2 ovf=0",
                     fd_seen - fd0, pix_count, overflow);
        end
    endtask

    task automatic test_href_drop();
        int fd0 = fd_seen;
        sof();
        pixel(8'h12, 8'h34, 1'b1);
        drop_pixel(8'hAB);
        pixel(8'h56, 8'h78, 1'b1);
        gap(1);
        checks++;
        if (last_addr !== 15'd1) begin
            errors++;
            $display("FAIL href_drop_addr got addr=%0d, required 1", last_addr);
        end
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) drop_pixel(8'($urandom));
            else pixel(8'($urandom), 8'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
        end
        eof();
        checks++;
        if (exp_q.size() != 0 || fd_seen - fd0 != 1 || pix_count !== AW'(m_count) || overflow !== m_ovf) begin
            errors++;
            $display("FAIL href_drop_frame got missing=%0d fd=%0d cnt=%0d ovf=%b, required missing=0 fd=1 cnt=%0d ovf=%b",
                     exp_q.size(), fd_seen - fd0, pix_count, overflow, m_count, m_ovf);
        end
    endtask

    task automatic test_simultaneous();
        int fd0 = fd_seen;
        int w0  = wr_seen;
        sof();
        pixel(8'hFF, 8'hFF, 1'b1);
        href    = 1'b1;
        px_data = 8'h5A;
        @(negedge clk);
        px_data = 8'hA5;
        vsync   = 1'b1;
        @(negedge clk);
        gap(3);
        checks++;
        if (wr_seen - w0 != 1 || fd_seen - fd0 != 1 || pix_count !== 15'd1) begin
            errors++;
            $display("FAIL vsync_vs_byte2 got writes=%0d fd=%0d cnt=%0d, required writes=1 fd=1 cnt=1",
                     wr_seen - w0, fd_seen - fd0, pix_count);
        end
    endtask

    task automatic test_reset_midframe();
        int w0;
        sof();
        pixel(8'hF8, 8'h1F, 1'b1);
        pixel(8'hF8, 8'h1F, 1'b1);
        href    = 1'b1;
        px_data = 8'hC3;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_if.px_wr, wr_if.mem_px_addr, wr_if.mem_px_data, frame_done, overflow, pix_count} !== 41'd0) begin
            errors++;
            $display("FAIL reset_midframe got wr=%b addr=%0d data=%h fd=%b ovf=%b cnt=%0d, required all 0",
                     wr_if.px_wr, wr_if.mem_px_addr, wr_if.mem_px_data, frame_done, overflow, pix_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        w0 = wr_seen;
        for (int i = 0; i < 10; i++) pixel(8'($urandom), 8'($urandom), 1'b0);
        gap(2);
        checks++;
        if (wr_seen != w0) begin
            errors++;
            $display("FAIL reset_no_write got writes=%0d, required 0", wr_seen - w0);
        end
        sof();
        pixel(8'h07, 8'hE0, 1'b1);
        gap(1);
        checks++;
        if (wr_seen - w0 != 1 || last_addr !== 15'd0 || last_data !== 8'h1C) begin
            errors++;
            $display("FAIL reset_restart got writes=%0d addr=%0d data=%h, required writes=1 addr=0 data=1c",
                     wr_seen - w0, last_addr, last_data);
        end
        eof();
    endtask

    task automatic test_full_frame();
        int fd0 = fd_seen;
        int w0  = wr_seen;
        sof();
        lines(MAX_PIX, 1'b1);
        eof();
        checks++;
        if (wr_seen - w0 != MAX_PIX || last_addr !== 15'd19199 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_frame_writes got writes=%0d last=%0d missing=%0d, required writes=19200 last=19199 missing=0",
                     wr_seen - w0, last_addr, exp_q.size());
        end
        checks++;
        if (fd_seen - fd0 != 1 || pix_count !== 15'd19200 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_frame_status got fd=%0d cnt=%0d ovf=%b, required fd=1 cnt=19200 ovf=0",
                     fd_seen - fd0, pix_count, overflow);
        end
    endtask

    task automatic test_overflow();
        int w0 = wr_seen;
        sof();
        lines(MAX_PIX, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_early got ovf=%b, required 0", overflow);
        end
        pixel(8'($urandom), 8'($urandom), 1'b1);
        gap(2);
        checks++;
        if (overflow !== 1'b1 || m_ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set got ovf=%b, required 1", overflow);
        end
        eof();
        checks++;
        if (wr_seen - w0 != MAX_PIX || pix_count !== 15'd19200 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_frame got writes=%0d cnt=%0d ovf=%b, required writes=19200 cnt=19200 ovf=1",
                     wr_seen - w0, pix_count, overflow);
        end
        sof();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got ovf=%b, required 0", overflow);
        end
        pixel(8'h84, 8'h10, 1'b1);
        gap(1);
        checks++;
        if (last_addr !== 15'd0) begin
            errors++;
            $display("FAIL overflow_next_addr got addr=%0d, required 0", last_addr);
        end
        eof();
    endtask

    task automatic test_disable();
        int fd0 = fd_seen;
        int w0  = wr_seen;
        sof();
        pixel(8'h11, 8'h22, 1'b1);
        capture_en = 1'b0;
        pixel(8'h33, 8'h44, 1'b1);
        eof();
        checks++;
        if (wr_seen - w0 != 2 || fd_seen - fd0 != 1 || pix_count !== 15'd2) begin
            errors++;
            $display("FAIL disable_midframe got writes=%0d fd=%0d cnt=%0d, required writes=2 fd=1 cnt=2",
                     wr_seen - w0, fd_seen - fd0, pix_count);
        end
        fd0 = fd_seen;
        w0  = wr_seen;
        vsync = 1'b0;
        gap(2);
        for (int i = 0; i < 8; i++) pixel(8'($urandom), 8'($urandom), 1'b0);
        eof();
        vsync = 1'b0;
        gap(2);
        for (int i = 0; i < 4; i++) pixel(8'($urandom), 8'($urandom), 1'b0);
        capture_en = 1'b1;
        for (int i = 0; i < 4; i++) pixel(8'($urandom), 8'($urandom), 1'b0);
        eof();
        checks++;
        if (wr_seen != w0 || fd_seen != fd0) begin
            errors++;
            $display("FAIL disabled_frames got writes=%0d fd=%0d, required writes=0 fd=0",
                     wr_seen - w0, fd_seen - fd0);
        end
        sof();
        pixel(8'hF8, 8'h1F, 1'b1);
        eof();
        checks++;
        if (wr_seen - w0 != 1 || last_addr !== 15'd0 || fd_seen - fd0 != 1 || pix_count !== 15'd1) begin
            errors++;
            $display("FAIL enable_next_frame got writes=%0d addr=%0d fd=%0d cnt=%0d, required writes=1 addr=0 fd=1 cnt=1",
                     wr_seen - w0, last_addr, fd_seen - fd0, pix_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_href_drop();
        test_simultaneous();
        test_reset_midframe();
        test_full_frame();
        test_overflow();
        test_disable();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_writes got %0d outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cam_rgb565_capture.md
Name: cam_rgb565_capture

Overview:
- Upstream stage of the dual-port frame buffer.
- Runs in the camera pixel-clock domain, which is the same clock as the buffer write port.
- Receives the OV7670-style byte stream (vsync, href, 8-bit data, 2 bytes per pixel, RGB565) and packs each pixel to RGB332.
- Drives the buffer write port (address, data, write strobe) for one 160x120 frame, limited to 19200 pixels.

Parameters:
- AW, 15, address width; matches the buffer address port.
- DW, 8, pixel width written to the buffer (RGB332).
- MAX_PIX, 19200, pixels per frame (160x120); addresses 0..MAX_PIX-1 are valid.

Ports:
- clk  in  1  camera pixel clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- capture_en  in  1  high = capture frames; sampled only at frame start.
- vsync  in  1  frame sync; high between frames.
- href  in  1  line valid; bytes are valid while high.
- px_data  in  8  camera byte.
- mem_px_addr  out  AW  buffer write address.
- mem_px_data  out  DW  RGB332 pixel.
- px_wr  out  1  one-cycle write strobe.
- frame_done  out  1  one-cycle pulse at the end of a captured frame.
- overflow  out  1  sticky per frame; more than MAX_PIX pixels were received.
- pix_count  out  AW  pixels written in the last completed frame.

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0, state IDLE, byte latch 0.
- FSM states: IDLE, WAIT_SOF, BYTE1, BYTE2.
- IDLE:
  - Go to WAIT_SOF when capture_en=1 and vsync=1.
- WAIT_SOF:
  - On vsync sampled 1 then 0 (falling edge), go to BYTE1.
  - Clear the address counter to 0 and clear overflow.
- BYTE1:
  - If href=1, latch px_data as hi byte and go to BYTE2.
- BYTE2:
  - If href=1, assemble the pixel: mem_px_data = {hi[7:5], hi[2:0], px_data[4:3]} (R3 G3 B2).
  - Next cycle: px_wr=1 with mem_px_addr = current count, then the count increments. Latency is 1 cycle from sampling byte 2 to the strobe.
  - Return to BYTE1.
  - If href=0 in BYTE2, discard the partial pixel and return to BYTE1 with no write.
- px_wr is a single-cycle pulse. mem_px_addr and mem_px_data hold their values between strobes.
- Overflow:
  - When the count reaches MAX_PIX, further completed pixels produce no px_wr.
  - overflow is set to 1 and held until the next start of frame.
  - The counter saturates at MAX_PIX and never wraps.
- End of frame:
  - A vsync rising edge in BYTE1 or BYTE2 aborts any partial pixel.
  - frame_done pulses 1 cycle; pix_count latches the counter (saturated).
  - If capture_en=1, go to WAIT_SOF; otherwise go to IDLE.
- Simultaneous events: when the vsync rising edge coincides with byte 2, vsync wins and the pixel is dropped.
- capture_en falling mid-frame has no effect until the end of that frame.
- Reset mid-frame: returns to IDLE and waits for a full vsync high-to-low before writing again. No write is ever issued with a partially assembled pixel.
- Edge detection uses a registered copy of vsync (prev_vsync), reset to 1.

Test Plan:
- Reset mid-frame: assert rst_n=0 during BYTE2 -> all outputs 0 the same cycle; after release, no px_wr until a vsync 1->0 is seen.
- Single pixel: after start of frame, href=1 with bytes 0xF8, 0x1F -> one px_wr, addr=0, data=0xE3. Second pixel 0x07, 0xE0 -> addr=1, data=0x1C.
- Full frame: 120 lines x 320 bytes, then vsync rise -> 19200 strobes, last addr=19199, frame_done pulses once, pix_count=19200, overflow=0.
- Overflow: 19201 pixels -> exactly 19200 strobes, overflow=1, pix_count=19200; next frame starts with addr=0 and overflow=0.
- href drops after the first byte of a pixel -> no strobe; the next pixel is written at the unchanged address.
- Disabled: capture_en=0 through vsync edges -> no px_wr, no frame_done. Enable mid-frame -> capture begins only at the next vsync falling edge.
